// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Multicycle MIPS control unit. Steps a shared-memory datapath
//            (one memory port, one ALU, one IR) through per-instruction
//            states and drives its mux selects, write enables and the 3-bit
//            ALU control. Instruction fetch and data accesses wait on the
//            memready handshake, so any of them may take several cycles.
// Options  : MC_JUMP_EN - when defined, adds the j instruction (DECODE ->
//            JEX -> FETCH). When undefined, op 000010 is illegal and state
//            encoding 11 behaves as an unused encoding.
// Ports    : clk, reset (sync, active-high)
//            op, funct       - IR fields, stable after FETCH
//            zero            - ALU zero flag (branch decision)
//            memready        - memory completes its access this cycle
//            pcen, irwrite, regwrite, memwrite - write enables
//            iord, memtoreg, regdst, alusrca, alusrcb, pcsrc - mux selects
//            alucontrol      - ALU operation
//            illegal         - one-cycle pulse on unsupported op/funct
//            state           - current state, for debug
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller #(
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic       w_funct_ok;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_illegal;
  logic [1:0] w_aluop;

  // Only the five supported R-type functions are legal.
  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default:                                               w_funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_illegal  = 1'b0;
    w_aluop    = c_ALUOP_ADD;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed every cycle but only committed, together with
        // the IR load, in the cycle the memory actually returns the word.
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
        w_next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut for a possible beq.
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW)             w_next = S_MEMADR;
        else if (op == OP_RTYPE && w_funct_ok)      w_next = S_RTYPEEX;
        else if (op == OP_BEQ)                      w_next = S_BEQEX;
        else if (op == OP_ADDI)                     w_next = S_ADDIEX;
`ifdef MC_JUMP_EN
        else if (op == OP_J)                        w_next = S_JEX;
`endif
        else begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        // Strobe is held for the whole access; the memory commits the write
        // once, in the cycle it raises memready.
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = c_ALUOP_FUNCT;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = c_ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
`endif
      default: begin
        // Unused encodings: everything idle, recover to FETCH.
        w_next = S_FETCH;
      end
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      c_ALUOP_ADD: alucontrol = 3'b010;
      c_ALUOP_SUB: alucontrol = 3'b110;
      c_ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Reset masks every side effect so an abandoned instruction writes nothing.
  assign pcen     = ~reset & (w_pcwrite | (w_branch & zero));
  assign irwrite  = ~reset & w_irwrite;
  assign regwrite = ~reset & w_regwrite;
  assign memwrite = ~reset & w_memwrite;
  assign illegal  = ~reset & w_illegal;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle MIPS control unit that sequences a shared-memory datapath: one memory port, one ALU, and an instruction register (IR). It decodes op/funct from the IR and steps through per-instruction states, driving mux selects, write enables and the 3-bit ALU control. It handles a memory-ready handshake so instruction fetch and data accesses may take several cycles. It replaces the single-cycle main decoder / ALU decoder pair when the datapath is built multicycle.

Parameters:
OP_LW, 6'b100011, load-word opcode
OP_SW, 6'b101011, store-word opcode
OP_RTYPE, 6'b000000, R-type opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode (used only with MC_JUMP_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  IR[31:26], held stable by the datapath after FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
memready  in  1  memory completes the current access this cycle
pcen  out  1  PC write enable = pcwrite | (branch & zero)
irwrite  out  1  IR load enable
regwrite  out  1  register file write enable
memwrite  out  1  memory write strobe
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memtoreg  out  1  write-back select: 0 = ALUOut, 1 = memory data
regdst  out  1  destination register select: 0 = rt, 1 = rd
alusrca  out  1  ALU A select: 0 = PC, 1 = rs
alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
pcsrc  out  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  out  3  ALU operation
illegal  out  1  one-cycle pulse: unsupported op or funct
state  out  4  current state, for debug

Behaviour:
- State register is the only storage. All outputs are combinational from state (plus memready, op and funct where noted).
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Unused encodings 12-15 go to FETCH on the next edge; all enables are 0 while in them.
- Reset: state <= FETCH on the edge. While reset=1, pcen, irwrite, regwrite, memwrite and illegal are forced 0. Reset mid-instruction abandons it with no further writes.
- Every output not listed for a state is 0.
- Internal aluop encoding: 00 = add, 01 = sub, 10 = by funct.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are 1 only in a cycle with memready=1.
  - Stay in FETCH while memready=0; go to DECODE when memready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - lw or sw -> MEMADR
  - R-type with supported funct -> RTYPEEX
  - beq -> BEQEX
  - addi -> ADDIEX
  - j (with macro) -> JEX
  - anything else -> illegal=1 this cycle, next state FETCH
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Hold until memready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1 on every cycle in the state. Hold until memready=1, then go to FETCH. The write completes exactly once.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, so pcen=zero. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- alucontrol decode:
  - aluop 00 -> 010; aluop 01 -> 110
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010; that funct is already flagged illegal in DECODE
- Latency with memready always 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Optional Feature:
MC_JUMP_EN
- Defined: op == OP_J goes DECODE -> JEX -> FETCH, and pcen=1 in JEX.
- Undefined: state JEX is unreachable; op 000010 raises illegal in DECODE and returns to FETCH. Encoding 11 then behaves as an unused encoding.

Test Plan:
- Reset held 3 cycles, then released with memready=1 -> state=0, all enables 0 during reset; first post-reset cycle shows irwrite=1, pcen=1.
- lw (op 100011), memready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; alucontrol=010 in states 0, 1 and 2.
- sw with memready=0 for 2 cycles in MEMWR -> memwrite=1 for 3 consecutive cycles, state holds 5, then goes to 0; regwrite stays 0 throughout.
- R-type funct 101010 -> alucontrol=111 in RTYPEEX, then regdst=1, regwrite=1. Repeat with funct 111111 -> illegal pulse in DECODE, then FETCH, and no regwrite occurs.
- beq with zero=1, then zero=0 -> pcen=1, pcsrc=01 in state 8 for zero=1; pcen=0 for zero=0; 3 cycles total each.
- op 000010 -> with MC_JUMP_EN: state 11, pcsrc=10, pcen=1. Without it: illegal=1 in DECODE and state 11 never visited.
